// File: rtl/data_cache_pkg.sv
// Shared types, field widths and address-field helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int CACHE_BLOCKS = 8;
    localparam int CPU_ADDR_W   = 8;
    localparam int OFFSET_W     = 2;
    localparam int INDEX_W      = $clog2(CACHE_BLOCKS);
    localparam int TAG_W        = CPU_ADDR_W - INDEX_W - OFFSET_W;
    localparam int MEM_ADDR_W   = TAG_W + INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    function automatic tag_t get_tag(input logic [CPU_ADDR_W-1:0] addr);
        return addr[CPU_ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t get_index(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic offset_t get_offset(input logic [CPU_ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Block-transfer bus between the cache (master) and the word-wide data memory (slave).
interface data_cache_if;
    import cache_pkg::*;

    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
    logic [31:0]           MEM_WRITEDATA;
    logic [31:0]           MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT
    );

endinterface

// File: rtl/data_cache_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read, synchronous byte write and line fill.
module data_cache_array
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = CACHE_BLOCKS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  index_t      index,
    input  logic        wr_en,
    input  offset_t     wr_offset,
    input  logic [7:0]  wr_byte,
    input  logic        fill_en,
    input  tag_t        fill_tag,
    input  logic [31:0] fill_data,
    output logic        rd_valid,
    output logic        rd_dirty,
    output tag_t        rd_tag,
    output logic [31:0] rd_data
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    logic [31:0]           data_q [NUM_BLOCKS];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index]   <= fill_tag;
            data_q[index]  <= fill_data;
        end else if (wr_en) begin
            data_q[index][{wr_offset, 3'b000} +: 8] <= wr_byte;
            dirty_q[index] <= 1'b1;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache; stalls the CPU while it services misses.
module data_cache
    import cache_pkg::*;
#(
    parameter int NUM_BLOCKS = CACHE_BLOCKS,
    parameter int ADDR_W     = CPU_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    data_cache_if.master      mem
);

    state_t      state;
    tag_t        req_tag;
    index_t      req_index;
    offset_t     req_offset;
    logic        line_valid;
    logic        line_dirty;
    tag_t        line_tag;
    logic [31:0] line_data;
    logic        hit;
    logic        req;
    logic        byte_wr;
    logic        fill;

    assign req_tag    = get_tag(ADDRESS);
    assign req_index  = get_index(ADDRESS);
    assign req_offset = get_offset(ADDRESS);

    assign hit     = line_valid && (line_tag == req_tag);
    assign req     = READ || WRITE;
    assign byte_wr = (state == IDLE) && WRITE && hit;
    assign fill    = (state == FETCH) && !mem.MEM_BUSYWAIT;

    // A pending write-allocate completes as an ordinary hit in the IDLE cycle after the fill.
    assign BUSYWAIT = (state != IDLE) || (req && !hit);
    assign READDATA = line_data[{req_offset, 3'b000} +: 8];

    data_cache_array #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_array (
        .CLK       (CLK),
        .RESET     (RESET),
        .index     (req_index),
        .wr_en     (byte_wr),
        .wr_offset (req_offset),
        .wr_byte   (WRITEDATA),
        .fill_en   (fill),
        .fill_tag  (req_tag),
        .fill_data (mem.MEM_READDATA),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state             <= IDLE;
            mem.MEM_READ      <= 1'b0;
            mem.MEM_WRITE     <= 1'b0;
            mem.MEM_ADDRESS   <= '0;
            mem.MEM_WRITEDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (line_valid && line_dirty) begin
                            state             <= WRITEBACK;
                            mem.MEM_WRITE     <= 1'b1;
                            mem.MEM_ADDRESS   <= {line_tag, req_index};
                            mem.MEM_WRITEDATA <= line_data;
                        end else begin
                            state           <= FETCH;
                            mem.MEM_READ    <= 1'b1;
                            mem.MEM_ADDRESS <= {req_tag, req_index};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem.MEM_BUSYWAIT) begin
                        state           <= FETCH;
                        mem.MEM_WRITE   <= 1'b0;
                        mem.MEM_READ    <= 1'b1;
                        mem.MEM_ADDRESS <= {req_tag, req_index};
                    end
                end
                FETCH: begin
                    if (!mem.MEM_BUSYWAIT) begin
                        state        <= IDLE;
                        mem.MEM_READ <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache against a word memory with a fixed 5-cycle busywait per transfer.
module tb_data_cache;
    import cache_pkg::*;

    localparam int unsigned L = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    data_cache_if mif ();

    data_cache #(
        .NUM_BLOCKS (8),
        .ADDR_W     (8)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .READ      (READ),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WRITEDATA (WRITEDATA),
        .READDATA  (READDATA),
        .BUSYWAIT  (BUSYWAIT),
        .mem       (mif)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int unsigned mcnt = 0;

    assign mif.MEM_BUSYWAIT = (mif.MEM_READ || mif.MEM_WRITE) && (mcnt < L);
    assign mif.MEM_READDATA = mem[mif.MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) begin
            mcnt <= 0;
        end else if (mif.MEM_READ || mif.MEM_WRITE) begin
            if (mcnt < L) begin
                mcnt <= mcnt + 1;
            end else begin
                mcnt <= 0;
                if (mif.MEM_WRITE) mem[mif.MEM_ADDRESS] <= mif.MEM_WRITEDATA;
            end
        end
    end

    // Observations gathered by access() over one stalled request.
    int          stall;
    int          rd_cycles;
    int          wr_cycles;
    int          both_high;
    int          unstable;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        #1;
        stall = 0; rd_cycles = 0; wr_cycles = 0; both_high = 0; unstable = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (BUSYWAIT && stall < 200) begin
            stall++;
            if (mif.MEM_READ && mif.MEM_WRITE) both_high++;
            if (mif.MEM_READ) begin
                if (rd_cycles > 0 && mif.MEM_ADDRESS != rd_addr) unstable++;
                rd_cycles++;
                rd_addr = mif.MEM_ADDRESS;
            end
            if (mif.MEM_WRITE) begin
                if (wr_cycles > 0 && (mif.MEM_ADDRESS != wr_addr || mif.MEM_WRITEDATA != wr_data)) unstable++;
                wr_cycles++;
                wr_addr = mif.MEM_ADDRESS;
                wr_data = mif.MEM_WRITEDATA;
            end
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic go_idle();
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (READDATA !== 8'h00) begin errors++; $display("FAIL reset_readdata got %h want %h", READDATA, 8'h00); end
        checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
        checks++; if (mif.MEM_READ !== 1'b0 || mif.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b want 00", mif.MEM_READ, mif.MEM_WRITE); end
        checks++; if (mif.MEM_ADDRESS !== 6'h00) begin errors++; $display("FAIL reset_mem_address got %h want 00", mif.MEM_ADDRESS); end
    endtask

    task automatic test_clean_miss();
        access(1'b1, 1'b0, 8'h00, 8'h00);
        checks++; if (stall !== 7) begin errors++; $display("FAIL clean_miss_stall got %0d want 7", stall); end
        checks++; if (rd_cycles !== 6 || wr_cycles !== 0) begin errors++; $display("FAIL clean_miss_strobes got rd %0d wr %0d want rd 6 wr 0", rd_cycles, wr_cycles); end
        checks++; if (rd_addr !== 6'h00) begin errors++; $display("FAIL clean_miss_addr got %h want 00", rd_addr); end
        checks++; if (READDATA !== 8'h11) begin errors++; $display("FAIL clean_miss_data got %h want 11", READDATA); end
    endtask

    task automatic test_hit_read();
        access(1'b1, 1'b0, 8'h01, 8'h00);
        checks++; if (stall !== 0) begin errors++; $display("FAIL hit_read_stall got %0d want 0", stall); end
        checks++; if (READDATA !== 8'h22) begin errors++; $display("FAIL hit_read_data got %h want 22", READDATA); end
        checks++; if (mif.MEM_READ !== 1'b0 || mif.MEM_WRITE !== 1'b0) begin errors++; $display("FAIL hit_read_strobes got %b%b want 00", mif.MEM_READ, mif.MEM_WRITE); end
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 8'h02, 8'hAB);
        checks++; if (stall !== 0) begin errors++; $display("FAIL write_hit_stall got %0d want 0", stall); end
        access(1'b1, 1'b0, 8'h02, 8'h00);
        checks++; if (stall !== 0) begin errors++; $display("FAIL write_hit_rd_stall got %0d want 0", stall); end
        checks++; if (READDATA !== 8'hAB) begin errors++; $display("FAIL write_hit_data got %h want ab", READDATA); end
    endtask

    task automatic test_dirty_evict();
        access(1'b1, 1'b0, 8'h22, 8'h00);
        checks++; if (stall !== 13) begin errors++; $display("FAIL dirty_evict_stall got %0d want 13", stall); end
        checks++; if (wr_cycles !== 6 || rd_cycles !== 6) begin errors++; $display("FAIL dirty_evict_strobes got wr %0d rd %0d want 6 6", wr_cycles, rd_cycles); end
        checks++; if (wr_addr !== 6'h00 || wr_data !== 32'h44AB2211) begin errors++; $display("FAIL dirty_evict_wb got %h %h want 00 44ab2211", wr_addr, wr_data); end
        checks++; if (rd_addr !== 6'h08) begin errors++; $display("FAIL dirty_evict_fetch_addr got %h want 08", rd_addr); end
        checks++; if (READDATA !== 8'h77) begin errors++; $display("FAIL dirty_evict_data got %h want 77", READDATA); end
        checks++; if (both_high !== 0 || unstable !== 0) begin errors++; $display("FAIL dirty_evict_bus got both %0d unstable %0d want 0 0", both_high, unstable); end
        checks++; if (mem[0] !== 32'h44AB2211) begin errors++; $display("FAIL dirty_evict_memword got %h want 44ab2211", mem[0]); end
        go_idle();
    endtask

    task automatic test_write_allocate();
        access(1'b0, 1'b1, 8'h45, 8'h5A);
        checks++; if (stall !== 7 || wr_cycles !== 0) begin errors++; $display("FAIL alloc_stall got %0d wr %0d want 7 0", stall, wr_cycles); end
        checks++; if (rd_addr !== 6'h11) begin errors++; $display("FAIL alloc_fetch_addr got %h want 11", rd_addr); end
        access(1'b1, 1'b0, 8'h45, 8'h00);
        checks++; if (stall !== 0 || READDATA !== 8'h5A) begin errors++; $display("FAIL alloc_readback got stall %0d data %h want 0 5a", stall, READDATA); end
        access(1'b1, 1'b0, 8'h65, 8'h00);
        checks++; if (stall !== 13) begin errors++; $display("FAIL alloc_evict_stall got %0d want 13", stall); end
        checks++; if (wr_addr !== 6'h11 || wr_data !== 32'hDDCC5AAA) begin errors++; $display("FAIL alloc_evict_wb got %h %h want 11 ddcc5aaa", wr_addr, wr_data); end
        checks++; if (rd_addr !== 6'h19 || READDATA !== 8'h0B) begin errors++; $display("FAIL alloc_evict_fetch got %h %h want 19 0b", rd_addr, READDATA); end
        go_idle();
    endtask

    task automatic test_read_write_both();
        access(1'b1, 1'b1, 8'h20, 8'h99);
        checks++; if (stall !== 0 || READDATA !== 8'h55) begin errors++; $display("FAIL rw_both_old got stall %0d data %h want 0 55", stall, READDATA); end
        access(1'b1, 1'b0, 8'h20, 8'h00);
        checks++; if (READDATA !== 8'h99) begin errors++; $display("FAIL rw_both_new got %h want 99", READDATA); end
        go_idle();
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h08;
        @(negedge CLK); #1;
        checks++; if (mif.MEM_READ !== 1'b1 || BUSYWAIT !== 1'b1) begin errors++; $display("FAIL midreset_fetching got rd %b busy %b want 1 1", mif.MEM_READ, BUSYWAIT); end
        RESET = 1'b1; READ = 1'b0;
        @(negedge CLK); #1;
        RESET = 1'b0;
        checks++; if (mif.MEM_READ !== 1'b0 || mif.MEM_WRITE !== 1'b0 || BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midreset_abort got rd %b wr %b busy %b want 0 0 0", mif.MEM_READ, mif.MEM_WRITE, BUSYWAIT); end
        access(1'b1, 1'b0, 8'h08, 8'h00);
        checks++; if (stall !== 7 || READDATA !== 8'hC3) begin errors++; $display("FAIL midreset_refetch got stall %0d data %h want 7 c3", stall, READDATA); end
        access(1'b1, 1'b0, 8'h01, 8'h00);
        checks++; if (stall !== 7 || READDATA !== 8'h22) begin errors++; $display("FAIL midreset_invalidated got stall %0d data %h want 7 22", stall, READDATA); end
        go_idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h00] = 32'h44332211;
        mem[6'h08] = 32'h88776655;
        mem[6'h11] = 32'hDDCCBBAA;
        mem[6'h19] = 32'h0D0C0B0A;
        mem[6'h02] = 32'h000000C3;

        test_reset();
        test_clean_miss();
        test_hit_read();
        test_write_hit();
        test_dirty_evict();
        test_write_allocate();
        test_read_write_both();
        test_reset_mid_fetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache that sits between the single-cycle CPU's load/store path and the 32-bit-word data memory. On a CPU request it returns or updates a byte. It holds the CPU via BUSYWAIT, the same stall signal that freezes the PC register. While the CPU is held, it services the miss as the requesting side of the memory's strobe/busywait handshake.

## Interface
Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width = log2(NUM_BLOCKS).
- ADDR_W, 8, CPU byte-address width; tag width = ADDR_W − log2(NUM_BLOCKS) − 2.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  in  8  store byte.
- READDATA  out  8  load byte; valid when BUSYWAIT=0 during READ.
- BUSYWAIT  out  1  stall to CPU/PC register.
- MEM_READ  out  1  block fetch strobe.
- MEM_WRITE  out  1  block write-back strobe.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  block being written back.
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory stall; high while a strobed transfer is in progress.

## Operation
- Per line: valid bit, dirty bit, tag, 32-bit data (byte k = bits [8k+7:8k]).
- hit = valid[index] & (tag[index] == ADDRESS tag).
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE:
  - No request: stay IDLE, BUSYWAIT=0.
  - Request and hit: BUSYWAIT=0.
    - READ: READDATA = selected byte, combinationally.
    - WRITE: byte written at the posedge; dirty set.
  - Request and miss, line clean or invalid: BUSYWAIT=1; next state FETCH.
  - Request and miss, line valid and dirty: BUSYWAIT=1; next state WRITEBACK.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data, BUSYWAIT=1.
  - Stays until a posedge with MEM_BUSYWAIT=0, then goes to FETCH.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}, BUSYWAIT=1.
  - At the posedge with MEM_BUSYWAIT=0: data ← MEM_READDATA, tag updated, valid=1, dirty=0, next state IDLE.
  - The request then resolves as a hit in IDLE. A write-allocate sets dirty at that point.
- Memory contract: the memory raises MEM_BUSYWAIT combinationally from the strobe and holds it high until its final cycle.
- CPU contract: READ, WRITE, ADDRESS and WRITEDATA are held stable while BUSYWAIT=1.
- READ and WRITE both high: treated as WRITE; READDATA still shows the old byte.
- Reset:
  - State IDLE; all valid, dirty, tag and data bits cleared.
  - All outputs 0, including READDATA=0.
  - A reset mid-transfer aborts it: strobes are 0 after the reset edge and no line is updated.

## Timing
- Hit: 0 stall cycles. A load returns in the same cycle; a store commits at that cycle's posedge.
- L = number of cycles MEM_BUSYWAIT stays high per transfer.
- Clean miss: BUSYWAIT high for L+2 cycles (1 IDLE + L+1 FETCH).
- Dirty miss: BUSYWAIT high for 2L+3 cycles.
- MEM_ADDRESS and MEM_WRITEDATA are stable for the whole time a strobe is high.
- Strobes are never both high. Each strobe is low in IDLE.
- The fill write and the state change to IDLE happen on the same edge.

## Structure
- Shared package cache_pkg:
  - state enum {IDLE, WRITEBACK, FETCH};
  - TAG_W, INDEX_W, OFFSET_W constants;
  - tag/index/offset field-extraction functions.
- One sub-module, data_cache_array, holds the valid/dirty/tag/data storage. It has a combinational read port and synchronous byte-write and line-fill ports with reset clear.
- FSM, hit compare and byte select live in data_cache.

## Test plan
- Reset, then READ 0x00 with memory L=5 → BUSYWAIT high for 7 cycles, MEM_READ with MEM_ADDRESS=0x00; block 0x44332211 loaded → READDATA=0x11.
- READ 0x01 immediately after → hit; BUSYWAIT=0 the same cycle, READDATA=0x22, no strobe.
- WRITE 0xAB to 0x02 (hit) → no stall; a following READ 0x02 gives 0xAB; line dirty.
- READ 0x22 (same index 0, different tag) → MEM_WRITE at MEM_ADDRESS=0x00 with data 0x44AB2211, then MEM_READ at MEM_ADDRESS=0x08; BUSYWAIT high for 13 cycles.
- WRITE to 0x45 (miss, clean) → fetch, then the byte is written and the line is dirty; the next eviction of that line writes it back.
- Assert RESET during FETCH → strobes drop after the edge; READ 0x00 misses again (valid cleared).
